cache_line_ctrl: RTL and testbench

//  Parametrised cache controller FSM; next generation of the single-cycle hit/miss control unit.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_line_ctrl_if.sv | 30 +++
 rtl/cache_stat_counter.sv | 18 +
 rtl/cache_line_ctrl.sv | 135 +++++++++++++
 tb/tb_cache_line_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache line controller.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_EVICT    = 3'd2,
    S_REFILL   = 3'd3,
    S_WT_WRITE = 3'd4,
    S_RESPOND  = 3'd5
  } state_t;

  localparam bit WB = 1'b1;
  localparam bit WT = 1'b0;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cache_line_ctrl_if.sv
// CPU, tag-compare, cache-array and memory handshake signals of the line controller.
interface cache_line_ctrl_if #(
  parameter int WORDS_PER_LINE = 4
);
  localparam int IDX_W = cache_pkg::idx_w(WORDS_PER_LINE);

  logic             req_valid;
  logic             req_we;
  logic             req_ready;
  logic             hit;
  logic             dirty;
  logic             mem_ack;
  logic             mem_rd;
  logic             mem_wr;
  logic [IDX_W-1:0] word_idx;
  logic             c_read;
  logic             c_write;
  logic             set_dirty;
  logic             resp_valid;

  modport master (
    input  req_valid, req_we, hit, dirty, mem_ack,
    output req_ready, mem_rd, mem_wr, word_idx, c_read, c_write, set_dirty, resp_valid
  );

  modport slave (
    output req_valid, req_we, hit, dirty, mem_ack,
    input  req_ready, mem_rd, mem_wr, word_idx, c_read, c_write, set_dirty, resp_valid
  );
endinterface

// File: rtl/cache_stat_counter.sv
// Saturating up-counter with asynchronous clear, used for hit/miss statistics.
module cache_stat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/cache_line_ctrl.sv
// Cache line controller: lookup, dirty eviction, multi-word refill, write-through
// and response sequencing, plus saturating hit/miss statistics.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | ready for a CPU request
// S_LOOKUP   | cache array read, hit/dirty sampled, statistics updated
// S_EVICT    | dirty line written back to memory one word per ack
// S_REFILL   | line fetched from memory one word per ack, then re-lookup
// S_WT_WRITE | write-through store held on memory until ack
// S_RESPOND  | one-cycle response to the CPU
module cache_line_ctrl
  import cache_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter bit WRITE_BACK     = 1'b1,
  parameter int STAT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  cache_line_ctrl_if.master bus,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int IDX_W  = idx_w(WORDS_PER_LINE);
  localparam bit POLICY = WRITE_BACK ? WB : WT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] word_idx, idx_nx;
  logic             we_q, we_nx;
  logic             resp_wr_q, resp_wr_nx;
  logic             wt_first, wt_first_nx;
  logic             lookup;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      word_idx  <= '0;
      we_q      <= 1'b0;
      resp_wr_q <= 1'b0;
      wt_first  <= 1'b0;
    end else begin
      state     <= state_nx;
      word_idx  <= idx_nx;
      we_q      <= we_nx;
      resp_wr_q <= resp_wr_nx;
      wt_first  <= wt_first_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = word_idx;
    we_nx       = we_q;
    resp_wr_nx  = resp_wr_q;
    wt_first_nx = 1'b0;
    lookup      = 1'b0;
    case (state)
      S_IDLE: begin
        resp_wr_nx = 1'b0;
        if (bus.req_valid) begin
          state_nx = S_LOOKUP;
          we_nx    = bus.req_we;
        end
      end
      S_LOOKUP: begin
        lookup     = 1'b1;
        resp_wr_nx = 1'b0;
        if (bus.hit) begin
          if (!we_q) begin
            state_nx = S_RESPOND;
          end else if (POLICY == WB) begin
            state_nx   = S_RESPOND;
            resp_wr_nx = 1'b1;
          end else begin
            state_nx    = S_WT_WRITE;
            wt_first_nx = 1'b1;
          end
        end else begin
          idx_nx   = '0;
          state_nx = ((POLICY == WB) && bus.dirty) ? S_EVICT : S_REFILL;
        end
      end
      S_EVICT: begin
        if (bus.mem_ack) begin
          idx_nx = word_idx + 1'b1;
          if (word_idx == LAST_IDX)
            state_nx = S_REFILL;
        end
      end
      S_REFILL: begin
        if (bus.mem_ack) begin
          idx_nx = word_idx + 1'b1;
          if (word_idx == LAST_IDX)
            state_nx = S_LOOKUP;
        end
      end
      S_WT_WRITE: begin
        if (bus.mem_ack)
          state_nx = S_RESPOND;
      end
      S_RESPOND: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Everything decodes from registered state; only the refill write strobe follows mem_ack.
  assign bus.req_ready  = (state == S_IDLE);
  assign bus.c_read     = (state == S_LOOKUP) || (state == S_EVICT);
  assign bus.mem_wr     = (state == S_EVICT) || (state == S_WT_WRITE);
  assign bus.mem_rd     = (state == S_REFILL);
  assign bus.word_idx   = word_idx;
  assign bus.resp_valid = (state == S_RESPOND);
  assign bus.set_dirty  = (state == S_RESPOND) && resp_wr_q;
  assign bus.c_write    = ((state == S_REFILL) && bus.mem_ack)
                       || ((state == S_WT_WRITE) && wt_first)
                       || ((state == S_RESPOND) && resp_wr_q);

  cache_stat_counter #(.W(STAT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lookup && bus.hit),
    .count (hit_cnt)
  );

  cache_stat_counter #(.W(STAT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lookup && !bus.hit),
    .count (miss_cnt)
  );

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Bench for cache_line_ctrl: a write-back instance (4 words, 16-bit stats) and a
// write-through instance (8 words, 2-bit stats) driven in turn against a transaction model.
module tb_cache_line_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit   sel = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, hit = 1'b0, dirty = 1'b0, mem_ack = 1'b0;

  cache_line_ctrl_if #(.WORDS_PER_LINE(4)) bus_a ();
  cache_line_ctrl_if #(.WORDS_PER_LINE(8)) bus_b ();
  logic [15:0] hit_cnt_a, miss_cnt_a;
  logic [1:0]  hit_cnt_b, miss_cnt_b;

  cache_line_ctrl #(.WORDS_PER_LINE(4), .WRITE_BACK(1'b1), .STAT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .hit_cnt(hit_cnt_a), .miss_cnt(miss_cnt_a));
  cache_line_ctrl #(.WORDS_PER_LINE(8), .WRITE_BACK(1'b0), .STAT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .hit_cnt(hit_cnt_b), .miss_cnt(miss_cnt_b));

  assign bus_a.req_valid = !sel && req_valid;
  assign bus_a.mem_ack   = !sel && mem_ack;
  assign bus_a.req_we    = req_we;
  assign bus_a.hit       = hit;
  assign bus_a.dirty     = dirty;
  assign bus_b.req_valid = sel && req_valid;
  assign bus_b.mem_ack   = sel && mem_ack;
  assign bus_b.req_we    = req_we;
  assign bus_b.hit       = hit;
  assign bus_b.dirty     = dirty;

  logic        dut_ready, dut_rd, dut_wr, dut_cwrite, dut_sd, dut_resp;
  logic [2:0]  dut_idx;
  logic [15:0] dut_hits, dut_misses;

  always_comb begin
    if (!sel) begin
      dut_ready = bus_a.req_ready;  dut_rd = bus_a.mem_rd;   dut_wr = bus_a.mem_wr;
      dut_cwrite = bus_a.c_write;   dut_sd = bus_a.set_dirty; dut_resp = bus_a.resp_valid;
      dut_idx = {1'b0, bus_a.word_idx};
      dut_hits = hit_cnt_a;         dut_misses = miss_cnt_a;
    end else begin
      dut_ready = bus_b.req_ready;  dut_rd = bus_b.mem_rd;   dut_wr = bus_b.mem_wr;
      dut_cwrite = bus_b.c_write;   dut_sd = bus_b.set_dirty; dut_resp = bus_b.resp_valid;
      dut_idx = bus_b.word_idx;
      dut_hits = {14'b0, hit_cnt_b}; dut_misses = {14'b0, miss_cnt_b};
    end
  end

  int tests = 0;
  int fails = 0;
  int m_hits[2]   = '{0, 0};
  int m_misses[2] = '{0, 0};
  int wpl[2]      = '{4, 8};
  bit wbp[2]      = '{1'b1, 1'b0};
  int cmax[2]     = '{65535, 3};

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One CPU request from acceptance to response; memory acks every d+1 cycles.
  task automatic run_txn(input bit we, input bit hv, input bit dv, input int d,
                         input bit noise, input string tag);
    int  w, n, resp_n, wc, cw, sd, wr_n, rd_n, idx_err, overlap, order_err;
    int  trans, lat_exp;
    bit  wb, done, busy;
    w  = wpl[sel];
    wb = wbp[sel];
    trans   = (!hv ? ((wb && dv) ? 2 * w : w) : 0) + ((we && !wb) ? 1 : 0);
    lat_exp = 2 + (!hv ? 1 : 0) + trans * (d + 1);
    check({tag, "_ready"}, dut_ready, 1);
    req_valid = 1'b1; req_we = we; hit = hv; dirty = dv; mem_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1; resp_n = -1; done = 1'b0; wc = 0; cw = 0; sd = 0;
    wr_n = 0; rd_n = 0; idx_err = 0; overlap = 0; order_err = 0;
    while (!done && n < 400) begin
      busy = dut_rd || dut_wr;
      if (dut_rd && dut_wr) overlap++;
      if (dut_sd) sd++;
      if (dut_resp) begin
        resp_n = n;
        done   = 1'b1;
      end
      if (busy) begin
        if (wc == d) begin mem_ack = 1'b1; wc = 0; end
        else begin mem_ack = 1'b0; wc++; end
      end else begin
        mem_ack = noise ? 1'($urandom_range(1)) : 1'b0;
        wc = 0;
      end
      if (noise) begin
        req_valid = 1'($urandom_range(1));
        req_we    = 1'($urandom_range(1));
      end
      #1;
      if (dut_cwrite) cw++;
      if (mem_ack && dut_rd) begin
        if (dut_idx !== 3'(rd_n % w)) idx_err++;
        rd_n++;
        if (rd_n == w) hit = 1'b1;
      end
      if (mem_ack && dut_wr) begin
        if (wb) begin
          if (dut_idx !== 3'(wr_n % w)) idx_err++;
          if (rd_n > 0) order_err++;
        end
        wr_n++;
      end
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    m_hits[sel] = (m_hits[sel] < cmax[sel]) ? m_hits[sel] + 1 : cmax[sel];
    if (!hv) m_misses[sel] = (m_misses[sel] < cmax[sel]) ? m_misses[sel] + 1 : cmax[sel];
    check({tag, "_latency"}, resp_n, lat_exp);
    check({tag, "_pulse"}, dut_resp, 0);
    check({tag, "_c_write"}, cw, (!hv ? w : 0) + (we ? 1 : 0));
    check({tag, "_set_dirty"}, sd, (we && wb) ? 1 : 0);
    check({tag, "_wr_words"}, wr_n, ((!hv && wb && dv) ? w : 0) + ((we && !wb) ? 1 : 0));
    check({tag, "_rd_words"}, rd_n, !hv ? w : 0);
    check({tag, "_word_idx"}, idx_err, 0);
    check({tag, "_overlap"}, overlap, 0);
    check({tag, "_order"}, order_err, 0);
    check({tag, "_hit_cnt"}, dut_hits, m_hits[sel]);
    check({tag, "_miss_cnt"}, dut_misses, m_misses[sel]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, dut_ready, 1);
    check({tag, "_mem_rd"}, dut_rd, 0);
    check({tag, "_mem_wr"}, dut_wr, 0);
    check({tag, "_c_write"}, dut_cwrite, 0);
    check({tag, "_resp"}, dut_resp, 0);
    check({tag, "_word_idx"}, dut_idx, 0);
    check({tag, "_hit_cnt"}, dut_hits, 0);
    check({tag, "_miss_cnt"}, dut_misses, 0);
  endtask

  initial begin
    bit found;
    @(negedge clk);
    sel = 1'b0; #1 check_reset_outputs("rst_a");
    sel = 1'b1; #1 check_reset_outputs("rst_b");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b0, 1'b1, 1'b0, 0, 1'b0, "wb_read_hit");
    run_txn(1'b0, 1'b0, 1'b0, 0, 1'b0, "wb_clean_miss");
    run_txn(1'b0, 1'b0, 1'b1, 0, 1'b0, "wb_dirty_miss");
    run_txn(1'b1, 1'b0, 1'b1, 1, 1'b1, "wb_dirty_wmiss");
    run_txn(1'b1, 1'b1, 1'b0, 2, 1'b1, "wb_write_hit");

    // Abort a refill part-way through with an asynchronous reset.
    req_valid = 1'b1; req_we = 1'b0; hit = 1'b0; dirty = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (dut_rd && dut_idx == 3'd2) found = 1'b1;
      else begin
        mem_ack = dut_rd;
        @(negedge clk);
      end
    end
    check("abort_reached", found, 1);
    mem_ack = 1'b1;
    #1 rst = 1'b1;
    #1 check("abort_mem_rd", dut_rd, 0);
    check("abort_ready", dut_ready, 1);
    check("abort_hit_cnt", dut_hits, 0);
    check("abort_miss_cnt", dut_misses, 0);
    check("abort_word_idx", dut_idx, 0);
    mem_ack = 1'b0;
    m_hits   = '{0, 0};
    m_misses = '{0, 0};
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(1'b0, 1'b0, 1'b0, 0, 1'b0, "post_abort_miss");

    repeat (25)
      run_txn(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              int'($urandom_range(2)), 1'b1, "rand_wb");

    sel = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 1'b1, 1'b0, 5, 1'b0, "wt_write_hit");
    run_txn(1'b0, 1'b0, 1'b1, 0, 1'b0, "wt_read_miss");
    run_txn(1'b1, 1'b0, 1'b1, 1, 1'b0, "wt_write_miss");
    repeat (5) run_txn(1'b0, 1'b1, 1'b0, 0, 1'b0, "wt_sat_hit");
    check("sat_hit_cnt", dut_hits, 3);

    repeat (25)
      run_txn(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
              int'($urandom_range(2)), 1'b1, "rand_wt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
